inst_loader: RTL
================

INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000: byte address of the first loaded word.
REQ-002 Parameter MAX_WORDS, default 1024: largest legal word count.
REQ-003 Parameter TIMEOUT_CYC, default 1_000_000: idle-cycle limit between bytes.
REQ-004 clk  input  1  single clock, rising-edge; reset is asynchronous, active-low; no other clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  one-cycle request to begin a load.
REQ-007 byte_i  input  8  incoming program byte, from the UART receiver.
REQ-008 byte_valid_i  input  1  byte_i valid.
REQ-009 byte_ready_o  output  1  loader accepts byte_i this cycle.
REQ-010 Inst_addr_load  output  32  word write address to the CPU load port.
REQ-011 Inst_load  output  32  instruction word to the CPU load port.
REQ-012 load_en  output  1  write strobe to the CPU load port.
REQ-013 cpu_rst_n  output  1  CPU core reset, active-low.
REQ-014 busy  output  1  load in progress.
REQ-015 done  output  1  load completed successfully.
REQ-016 err  output  1  load aborted (length or timeout).

Function
REQ-017 Byte transfer occurs only on a cycle with byte_valid_i=1 and byte_ready_o=1.
REQ-018 States: IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR.
REQ-019 IDLE/DONE/ERR: start=1 -> LEN_LO next cycle, which clears the address, byte index, word count and timeout counter; start is ignored in every other state.
REQ-020 LEN_LO: accepted byte -> count[7:0], go to LEN_HI; LEN_HI: accepted byte -> count[15:8].
REQ-021 LEN_HI exit, same cycle the byte is accepted:
- count == 0 -> DONE.
- count > MAX_WORDS -> ERR.
- Otherwise -> DATA.
REQ-022 DATA assembles little-endian: byte k of the word goes to bits [8k+7:8k], k = 0..3.
REQ-023 On the 4th accepted byte, DATA -> WRITE.
REQ-024 WRITE lasts exactly one cycle:
- load_en = 1.
- Inst_load = assembled word.
- Inst_addr_load = BASE_ADDR + 4*word_index.
REQ-025 WRITE exit: last word -> DONE; otherwise -> DATA, with word_index incremented.
REQ-026 byte_ready_o = 1 only in LEN_LO, LEN_HI and DATA; 0 in WRITE, so at most one write is outstanding.
REQ-027 Inst_addr_load and Inst_load hold their last values outside WRITE; load_en = 0 outside WRITE.
REQ-028 Timeout counter:
- Increments each cycle in LEN_LO, LEN_HI or DATA with no byte transfer.
- Clears on each transfer.
- Reaching TIMEOUT_CYC -> ERR.
REQ-029 A transfer and the timeout limit in the same cycle: the transfer wins.
REQ-030 busy = 1 in LEN_LO, LEN_HI, DATA and WRITE.
REQ-031 done = 1 only in DONE; err = 1 only in ERR; both are registered levels, held until the next start.
REQ-032 cpu_rst_n = 1 only in DONE; it is 0 in all other states, so a reload or failed load holds the CPU in reset.
REQ-033 Address arithmetic is 32-bit and wraps modulo 2^32 without flagging.

Reset
REQ-034 rst_n low, asynchronously:
- State goes to IDLE.
- Outputs: byte_ready_o=0, load_en=0, Inst_addr_load=0, Inst_load=0, cpu_rst_n=0, busy=0, done=0, err=0.
REQ-035 Reset mid-load abandons the load; no partial word is written after rst_n rises.
REQ-036 rst_n is deasserted synchronously to clk by the system reset synchronizer; the loader does not resynchronize it.

Structure
REQ-037 State encodings, the default BASE_ADDR and the length-header width (16) are defined as constants in define.v.
REQ-038 The timeout counter is a sub-module, loader_timeout (inputs: count-enable, clear; output: expired).
REQ-039 Inside inst_loader all outputs are registered, with no combinational path from byte_i or byte_valid_i to any output.
REQ-040 byte_ready_o is the one exception: it is decoded from state only.

Verification
REQ-041 start, then bytes 02 00 13 05 A0 00 93 05 B0 00 -> two load_en pulses:
- Pulse 1: (addr 0x0, data 0x00A00513).
- Pulse 2: (addr 0x4, data 0x00B00593).
- Afterwards done=1 and cpu_rst_n=1.
REQ-042 start, then bytes 00 00 -> DONE with zero load_en pulses.
REQ-043 MAX_WORDS=4, start, then bytes 05 00 -> err=1 on the cycle after the 2nd byte; cpu_rst_n stays 0.
REQ-044 TIMEOUT_CYC=16, start, then one data byte and no further input -> err=1 exactly 16 cycles after that byte; no load_en.
REQ-045 Throttled stream: byte_valid_i toggles randomly and a byte is offered during WRITE -> that byte is not accepted during WRITE; all words written correctly in order.
REQ-046 rst_n pulsed low after byte 3 of word 1 -> outputs return to reset values at once; a subsequent start reloads from addr BASE_ADDR.

Source files
------------

// File: rtl/inst_loader_pkg.sv
// Shared constants, state encoding and address helper for the program loader.
package inst_loader_pkg;

   localparam int          LEN_W         = 16;
   localparam logic [31:0] DEF_BASE_ADDR = 32'h0000_0000;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_LO,
      S_LEN_HI,
      S_DATA,
      S_WRITE,
      S_DONE,
      S_ERR
   } state_t;

   // Byte address of a word slot; wraps modulo 2^32 by construction.
   function automatic logic [31:0] word_addr(input logic [31:0] base,
                                             input logic [LEN_W-1:0] idx);
      return base + {14'd0, idx, 2'b00};
   endfunction

endpackage

// File: rtl/loader_timeout.sv
// Idle-cycle watchdog: counts cycles with no byte transfer while a load
// is waiting for input; expired fires on the cycle the count would reach
// the limit.
module loader_timeout #(
   parameter int TIMEOUT_CYC = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic cnt_en,
   input  logic clr,
   output logic expired
);

   localparam int W = $clog2(TIMEOUT_CYC + 1);

   logic [W-1:0] cnt;

   // Idle counter; clear has priority so a transfer always restarts it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      cnt <= '0;
      else if (clr)    cnt <= '0;
      else if (cnt_en) cnt <= cnt + W'(1);
   end

   assign expired = cnt_en && (cnt == W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/inst_loader.sv
// Streams a length-prefixed little-endian program from a byte source into
// the CPU instruction load port, holding the CPU in reset until the whole
// image has been written.
module inst_loader
   import inst_loader_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
   parameter int          MAX_WORDS   = 1024,
   parameter int          TIMEOUT_CYC = 1_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  byte_i,
   input  logic        byte_valid_i,
   output logic        byte_ready_o,
   output logic [31:0] Inst_addr_load,
   output logic [31:0] Inst_load,
   output logic        load_en,
   output logic        cpu_rst_n,
   output logic        busy,
   output logic        done,
   output logic        err
);

   state_t             state, state_nxt;
   logic [LEN_W-1:0]   len_q;
   logic [LEN_W-1:0]   word_idx;
   logic [1:0]         byte_idx;
   logic [23:0]        asm_q;
   logic [LEN_W-1:0]   len_full;
   logic               xfer;
   logic               last_word;
   logic               tmo_exp;

   // Ready depends on state alone so the source never sees a comb loop.
   assign byte_ready_o = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                         (state == S_DATA);
   assign xfer         = byte_valid_i && byte_ready_o;
   assign len_full     = {byte_i, len_q[7:0]};
   assign last_word    = (word_idx == len_q - LEN_W'(1));

   loader_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
      .clk    (clk),
      .rst_n  (rst_n),
      .cnt_en (byte_ready_o && !byte_valid_i),
      .clr    (!byte_ready_o || byte_valid_i),
      .expired(tmo_exp)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state decode; a transfer always beats the timeout.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE, S_ERR: if (start) state_nxt = S_LEN_LO;
         S_LEN_LO: begin
            if (xfer)         state_nxt = S_LEN_HI;
            else if (tmo_exp) state_nxt = S_ERR;
         end
         S_LEN_HI: begin
            if (xfer) begin
               if (len_full == '0)                             state_nxt = S_DONE;
               else if ({16'd0, len_full} > $unsigned(MAX_WORDS)) state_nxt = S_ERR;
               else                                            state_nxt = S_DATA;
            end else if (tmo_exp) begin
               state_nxt = S_ERR;
            end
         end
         S_DATA: begin
            if (xfer && byte_idx == 2'd3) state_nxt = S_WRITE;
            else if (tmo_exp)             state_nxt = S_ERR;
         end
         S_WRITE:  state_nxt = last_word ? S_DONE : S_DATA;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Datapath and registered outputs, all decoded from the next state so
   // they line up with the state they describe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_q          <= '0;
         word_idx       <= '0;
         byte_idx       <= '0;
         asm_q          <= '0;
         Inst_addr_load <= '0;
         Inst_load      <= '0;
         load_en        <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         err            <= 1'b0;
         cpu_rst_n      <= 1'b0;
      end else begin
         load_en   <= (state_nxt == S_WRITE);
         busy      <= (state_nxt == S_LEN_LO) || (state_nxt == S_LEN_HI) ||
                      (state_nxt == S_DATA)   || (state_nxt == S_WRITE);
         done      <= (state_nxt == S_DONE);
         err       <= (state_nxt == S_ERR);
         cpu_rst_n <= (state_nxt == S_DONE);
         case (state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  len_q    <= '0;
                  word_idx <= '0;
                  byte_idx <= '0;
                  asm_q    <= '0;
               end
            end
            S_LEN_LO: if (xfer) len_q[7:0]  <= byte_i;
            S_LEN_HI: if (xfer) len_q[15:8] <= byte_i;
            S_DATA: begin
               if (xfer) begin
                  byte_idx <= byte_idx + 2'd1;
                  case (byte_idx)
                     2'd0:    asm_q[7:0]   <= byte_i;
                     2'd1:    asm_q[15:8]  <= byte_i;
                     2'd2:    asm_q[23:16] <= byte_i;
                     default: begin
                        Inst_load      <= {byte_i, asm_q};
                        Inst_addr_load <= word_addr(BASE_ADDR, word_idx);
                     end
                  endcase
               end
            end
            S_WRITE: if (!last_word) word_idx <= word_idx + LEN_W'(1);
            default: ;
         endcase
      end
   end

endmodule
